// File: rtl/irq_prio_sched_pkg.sv
// Shared types and constants for the interrupt priority scheduler.
//   state_t      : handshake state encoding (IDLE, REQ, VEC, HOLD)
//   NLINES       : number of interrupt lines
//   VECBASE_DEF  : default vector address of IRQ0
//   SPURIOUS_DEF : default vector returned when no request survives acknowledge
package irq_prio_sched_pkg;

  localparam int NLINES = 8;
  localparam logic [15:0] VECBASE_DEF  = 16'h0008;
  localparam logic [15:0] SPURIOUS_DEF = 16'h0020;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_VEC,
    ST_HOLD
  } state_t;

  // IRQn vector = base + 2*n, 16-bit modulo.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [2:0] idx);
    return base + {12'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_prio_sched_if.sv
// Bus between interrupt controller / CPU and the priority scheduler.
//   irq_pend     : masked pending flags, bit n = IRQn
//   int_en       : CPU global interrupt enable
//   cpu_iack     : CPU acknowledge level, held until vector_valid is seen
//   eoi          : one-cycle non-specific end-of-interrupt strobe
//   nirq         : active-low interrupt request to CPU
//   vector       : vector address, valid while vector_valid is high
//   vector_valid : one-cycle vector strobe
//   clr_irq      : one-hot one-cycle clear to the controller
//   in_service   : in-service register
interface irq_prio_sched_if;
  import irq_prio_sched_pkg::*;

  logic [NLINES-1:0] irq_pend;
  logic              int_en;
  logic              cpu_iack;
  logic              eoi;
  logic              nirq;
  logic [15:0]       vector;
  logic              vector_valid;
  logic [NLINES-1:0] clr_irq;
  logic [NLINES-1:0] in_service;

  // Scheduler side.
  modport slave (
    input  irq_pend, int_en, cpu_iack, eoi,
    output nirq, vector, vector_valid, clr_irq, in_service
  );

  // Controller/CPU side.
  modport master (
    output irq_pend, int_en, cpu_iack, eoi,
    input  nirq, vector, vector_valid, clr_irq, in_service
  );
endinterface

// File: rtl/irq_prio_sched_prio_enc8.sv
// Combinational 8-bit priority encoder, lowest set bit wins.
//   i_vec   : input bits
//   o_idx   : index of the lowest set bit (0 when none)
//   o_found : at least one bit set
module prio_enc8
  import irq_prio_sched_pkg::*;
(
  input  logic [NLINES-1:0] i_vec,
  output logic [2:0]        o_idx,
  output logic              o_found
);

  // Scan from the top down so the lowest set bit is written last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = NLINES; i > 0; i--) begin
      if (i_vec[3'(i - 1)]) begin
        o_idx   = 3'(i - 1);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_prio_sched.sv
// Interrupt priority scheduler: picks the highest-priority pending request
// that may pre-empt current service, runs the CPU request/acknowledge/vector
// handshake, pulses a clear to the controller and tracks in-service levels
// for nesting and EOI.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   sched_bus : irq_prio_sched_if.slave (pending/enable/ack/eoi in,
//               nirq/vector/vector_valid/clr_irq/in_service out)
module irq_prio_sched
  import irq_prio_sched_pkg::*;
#(
  parameter logic [15:0] VECBASE  = VECBASE_DEF,
  parameter logic [15:0] SPURIOUS = SPURIOUS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  irq_prio_sched_if.slave    sched_bus
);

  state_t            r_state;
  logic              r_nirq;
  logic [15:0]       r_vector;
  logic              r_vector_valid;
  logic [NLINES-1:0] r_clr_irq;
  logic [NLINES-1:0] r_in_service;
  logic [2:0]        r_win_idx;
  logic              r_win_found;

  logic [2:0]        w_pend_idx;
  logic              w_pend_found;
  logic [2:0]        w_is_idx;
  logic              w_is_found;
  logic              w_cand_found;
  logic              w_eligible;
  logic [NLINES-1:0] w_cand_onehot;
  logic [NLINES-1:0] w_in_service_next;

  prio_enc8 u_enc_pend (
    .i_vec   (sched_bus.irq_pend),
    .o_idx   (w_pend_idx),
    .o_found (w_pend_found)
  );

  prio_enc8 u_enc_is (
    .i_vec   (r_in_service),
    .o_idx   (w_is_idx),
    .o_found (w_is_found)
  );

  // Only the lowest pending line can be a candidate: if it is not above the
  // highest-priority in-service level, no higher-numbered line can be.
  always_comb begin
    w_cand_found  = w_pend_found && (!w_is_found || (w_pend_idx < w_is_idx));
    w_eligible    = sched_bus.int_en && w_cand_found;
    w_cand_onehot = '0;
    w_cand_onehot[w_pend_idx] = w_cand_found;
  end

  // EOI clears against the pre-VEC register; the new winner bit is OR'd in
  // afterwards so both land on the same edge.
  always_comb begin
    w_in_service_next = r_in_service;
    if (sched_bus.eoi && w_is_found) begin
      w_in_service_next[w_is_idx] = 1'b0;
    end
    if ((r_state == ST_VEC) && r_win_found) begin
      w_in_service_next[r_win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_nirq         <= 1'b1;
      r_vector       <= '0;
      r_vector_valid <= 1'b0;
      r_clr_irq      <= '0;
      r_in_service   <= '0;
      r_win_idx      <= '0;
      r_win_found    <= 1'b0;
    end else begin
      r_vector_valid <= 1'b0;
      r_clr_irq      <= '0;
      r_in_service   <= w_in_service_next;
      case (r_state)
        ST_IDLE: begin
          if (w_eligible) begin
            r_state <= ST_REQ;
            r_nirq  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (sched_bus.cpu_iack) begin
            r_state        <= ST_VEC;
            r_nirq         <= 1'b1;
            r_win_idx      <= w_pend_idx;
            r_win_found    <= w_cand_found;
            r_vector_valid <= 1'b1;
            r_vector       <= w_cand_found ? vec_addr(VECBASE, w_pend_idx) : SPURIOUS;
            r_clr_irq      <= w_cand_onehot;
          end else if (!w_eligible) begin
            r_state <= ST_IDLE;
            r_nirq  <= 1'b1;
          end
        end
        ST_VEC: begin
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!sched_bus.cpu_iack) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sched_bus.nirq         = r_nirq;
  assign sched_bus.vector       = r_vector;
  assign sched_bus.vector_valid = r_vector_valid;
  assign sched_bus.clr_irq      = r_clr_irq;
  assign sched_bus.in_service   = r_in_service;

endmodule

// File: tb/tb_irq_prio_sched.sv
module tb_irq_prio_sched;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  irq_prio_sched_if bus();

  irq_prio_sched #(
    .VECBASE  (16'h0008),
    .SPURIOUS (16'h0020)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sched_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  pend;
    logic        en;
    logic        iack;
    logic        eoi;
    logic        nirq;
    logic        vv;
    logic [15:0] vec;
    logic [7:0]  clr;
    logic [7:0]  is;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic [7:0] pend, input logic en,
                     input logic iack, input logic eoi, input logic nirq,
                     input logic vv, input logic [15:0] vec, input logic [7:0] clr,
                     input logic [7:0] is);
    vec_t v;
    v.rst = rst; v.pend = pend; v.en = en; v.iack = iack; v.eoi = eoi;
    v.nirq = nirq; v.vv = vv; v.vec = vec; v.clr = clr; v.is = is;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic [7:0] pend, input logic en,
                     input logic iack, input logic eoi);
    reset        = rst;
    bus.irq_pend = pend;
    bus.int_en   = en;
    bus.cpu_iack = iack;
    bus.eoi      = eoi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic nirq, input logic vv,
                         input logic [15:0] vec, input logic [7:0] clr, input logic [7:0] is);
    chk({tag, ".nirq"}, 16'(bus.nirq), 16'(nirq));
    chk({tag, ".vv"},   16'(bus.vector_valid), 16'(vv));
    chk({tag, ".vec"},  bus.vector, vec);
    chk({tag, ".clr"},  16'(bus.clr_irq), 16'(clr));
    chk({tag, ".is"},   16'(bus.in_service), 16'(is));
  endtask

  // Reference model: handshake described as flags, priority by scanning lines.
  bit          m_asking;      // request line to CPU is active
  bit          m_vec_cycle;   // vector is on the bus this cycle
  bit          m_wait_rel;    // waiting for CPU to drop acknowledge
  int          m_win;         // line granted at acknowledge, -1 = spurious
  bit          m_nirq, m_vv;
  logic [15:0] m_vec;
  logic [7:0]  m_clr, m_is;

  function automatic int lowest(input logic [7:0] x);
    for (int n = 0; n < 8; n++) if (x[n]) return n;
    return 8;
  endfunction

  task automatic model_step(input logic rst, input logic [7:0] pend, input logic en,
                            input logic iack, input logic eoi);
    int cand, top_is;
    bit has_cand;
    logic [7:0] nis;
    if (rst) begin
      m_asking = 0; m_vec_cycle = 0; m_wait_rel = 0; m_win = -1;
      m_nirq = 1; m_vv = 0; m_vec = 0; m_clr = 0; m_is = 0;
      return;
    end
    cand     = lowest(pend);
    top_is   = lowest(m_is);
    has_cand = (cand < 8) && (cand < top_is);
    nis = m_is;
    if (eoi && top_is < 8) nis[top_is] = 1'b0;
    if (m_vec_cycle && m_win >= 0) nis[m_win] = 1'b1;
    m_vv = 0; m_clr = 0;
    if (m_vec_cycle) begin
      m_vec_cycle = 0; m_wait_rel = 1;
    end else if (m_wait_rel) begin
      if (!iack) m_wait_rel = 0;
    end else if (m_asking) begin
      if (iack) begin
        m_asking = 0; m_vec_cycle = 1; m_vv = 1;
        m_win = has_cand ? cand : -1;
        m_vec = has_cand ? 16'(8 + 2 * cand) : 16'h0020;
        if (has_cand) m_clr[cand] = 1'b1;
      end else if (!(en && has_cand)) begin
        m_asking = 0;
      end
    end else if (en && has_cand) begin
      m_asking = 1;
    end
    m_is   = nis;
    m_nirq = !m_asking;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; bus.irq_pend = '0; bus.int_en = 1'b0; bus.cpu_iack = 1'b0; bus.eoi = 1'b0;

    //   rst pend   en iack eoi | nirq vv vec       clr    is
    add(1, 8'hFF, 1, 0, 0,   1, 0, 16'h0000, 8'h00, 8'h00); // reset with all pending
    add(1, 8'hFF, 1, 0, 0,   1, 0, 16'h0000, 8'h00, 8'h00);
    add(0, 8'hFF, 1, 0, 0,   0, 0, 16'h0000, 8'h00, 8'h00); // nirq one cycle after release
    add(0, 8'h10, 1, 1, 0,   1, 1, 16'h0010, 8'h10, 8'h00); // single request IRQ4
    add(0, 8'h00, 1, 1, 0,   1, 0, 16'h0010, 8'h00, 8'h10);
    add(0, 8'h00, 1, 1, 0,   1, 0, 16'h0010, 8'h00, 8'h10); // held in HOLD
    add(0, 8'h00, 1, 0, 0,   1, 0, 16'h0010, 8'h00, 8'h10);
    add(0, 8'h00, 1, 0, 1,   1, 0, 16'h0010, 8'h00, 8'h00); // eoi
    add(0, 8'h50, 1, 0, 0,   0, 0, 16'h0010, 8'h00, 8'h00); // 0x50 -> IRQ4 wins
    add(0, 8'h50, 1, 1, 0,   1, 1, 16'h0010, 8'h10, 8'h00);
    add(0, 8'h40, 1, 1, 0,   1, 0, 16'h0010, 8'h00, 8'h10);
    add(0, 8'h40, 1, 0, 0,   1, 0, 16'h0010, 8'h00, 8'h10);
    add(0, 8'h40, 1, 0, 0,   1, 0, 16'h0010, 8'h00, 8'h10); // IRQ6 blocked by IRQ4
    add(0, 8'h42, 1, 0, 0,   0, 0, 16'h0010, 8'h00, 8'h10); // IRQ1 nests
    add(0, 8'h42, 1, 1, 0,   1, 1, 16'h000A, 8'h02, 8'h10);
    add(0, 8'h40, 1, 0, 0,   1, 0, 16'h000A, 8'h00, 8'h12);
    add(0, 8'h40, 1, 0, 0,   1, 0, 16'h000A, 8'h00, 8'h12);
    add(0, 8'h40, 1, 0, 1,   1, 0, 16'h000A, 8'h00, 8'h10); // eoi drops IRQ1
    add(0, 8'h04, 1, 0, 0,   0, 0, 16'h000A, 8'h00, 8'h10); // withdrawal
    add(0, 8'h00, 1, 0, 0,   1, 0, 16'h000A, 8'h00, 8'h10);
    add(0, 8'h04, 1, 0, 0,   0, 0, 16'h000A, 8'h00, 8'h10);
    add(0, 8'h00, 1, 1, 0,   1, 1, 16'h0020, 8'h00, 8'h10); // spurious
    add(0, 8'h00, 1, 0, 0,   1, 0, 16'h0020, 8'h00, 8'h10);
    add(0, 8'h00, 1, 0, 0,   1, 0, 16'h0020, 8'h00, 8'h10);
    add(0, 8'hFF, 0, 0, 0,   1, 0, 16'h0020, 8'h00, 8'h10); // int_en gating
    add(0, 8'hFF, 0, 0, 0,   1, 0, 16'h0020, 8'h00, 8'h10);
    add(0, 8'hFF, 1, 0, 0,   0, 0, 16'h0020, 8'h00, 8'h10);
    add(0, 8'hFF, 1, 1, 0,   1, 1, 16'h0008, 8'h01, 8'h10);
    add(0, 8'hFE, 1, 0, 0,   1, 0, 16'h0008, 8'h00, 8'h11);
    add(0, 8'hFE, 1, 0, 0,   1, 0, 16'h0008, 8'h00, 8'h11);
    add(0, 8'h00, 1, 0, 1,   1, 0, 16'h0008, 8'h00, 8'h10);
    add(0, 8'h00, 1, 0, 1,   1, 0, 16'h0008, 8'h00, 8'h00);

    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].pend, tv[i].en, tv[i].iack, tv[i].eoi);
      chk_all($sformatf("vec%0d", i), tv[i].nirq, tv[i].vv, tv[i].vec, tv[i].clr, tv[i].is);
    end

    // eoi in the VEC cycle: in_service 0x20, winner IRQ2 -> 0x04
    cyc(1, 8'h00, 1, 0, 0);
    cyc(0, 8'h20, 1, 0, 0);
    cyc(0, 8'h20, 1, 1, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("eoivec.pre_is", 16'(bus.in_service), 16'h0020);
    cyc(0, 8'h04, 1, 0, 0);
    cyc(0, 8'h04, 1, 1, 0);
    chk("eoivec.vec", bus.vector, 16'h000C);
    cyc(0, 8'h00, 1, 1, 1);
    chk("eoivec.is", 16'(bus.in_service), 16'h0004);
    cyc(0, 8'h00, 1, 0, 0);

    // reset while in HOLD
    cyc(1, 8'h00, 1, 0, 0);
    cyc(0, 8'h01, 1, 0, 0);
    cyc(0, 8'h01, 1, 1, 0);
    cyc(0, 8'h00, 1, 1, 0);
    cyc(0, 8'h00, 1, 1, 0);
    chk("rsthold.is_before", 16'(bus.in_service), 16'h0001);
    cyc(1, 8'h01, 1, 1, 0);
    chk_all("rsthold", 1, 0, 16'h0000, 8'h00, 8'h00);
    cyc(0, 8'h01, 1, 0, 0);
    chk("rsthold.idle_nirq", 16'(bus.nirq), 16'h0000);

    // randomized against the reference model
    model_step(1, 0, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      logic        r_rst, r_en, r_iack, r_eoi;
      logic [7:0]  r_pend;
      r_rst  = ($urandom_range(0, 299) == 0);
      r_en   = ($urandom_range(0, 9) != 0);
      r_iack = ($urandom_range(0, 2) == 0) ? !bus.cpu_iack : bus.cpu_iack;
      r_eoi  = ($urandom_range(0, 7) == 0);
      r_pend = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom) & 8'($urandom));
      model_step(r_rst, r_pend, r_en, r_iack, r_eoi);
      cyc(r_rst, r_pend, r_en, r_iack, r_eoi);
      chk_all($sformatf("rand%0d", k), m_nirq, m_vv, m_vec, m_clr, m_is);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_prio_sched.md
Name: irq_prio_sched

Overview:
Interrupt priority scheduler between the 8-line interrupt controller (IRQ mask/status at I/O 0x30) and the CPU. It takes the controller's masked pending flags and picks the highest-priority request that may pre-empt current service. It drives the CPU interrupt request, runs the acknowledge/vector handshake, and pulses a clear back to the controller. It also tracks in-service levels for nesting and end-of-interrupt (EOI).

Parameters:
VECBASE, 16'h0008, vector address of IRQ0; IRQn vector = VECBASE + 2*n
SPURIOUS, 16'h0020, vector returned when an acknowledge finds no eligible request
NLINES, 8, number of IRQ lines (fixed at 8 in this revision)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
irq_pend  in  8  masked pending flags from the interrupt controller, bit n = IRQn
int_en  in  1  CPU global interrupt enable
cpu_iack  in  1  CPU acknowledge request, level; held high until vector_valid is seen
eoi  in  1  one-cycle end-of-interrupt strobe (non-specific)
nirq  out  1  active-low interrupt request to CPU
vector  out  16  vector address, valid while vector_valid is high
vector_valid  out  1  one-cycle strobe
clr_irq  out  8  one-hot, one-cycle clear strobe to the controller
in_service  out  8  in-service register, bit n = IRQn being serviced

Behaviour:
- Reset values: nirq=1, vector=0, vector_valid=0, clr_irq=0, in_service=0, state=IDLE. Reset has priority over every other input.
- Priority: IRQ0 highest, IRQ7 lowest.
- cand = lowest-numbered set bit of irq_pend whose number is below the lowest-numbered set bit of in_service. Every pending line qualifies when in_service=0.
- eligible = int_en & (cand exists). Purely combinational from registered in_service and input irq_pend.
- States:
  - IDLE: nirq=1. If eligible, go to REQ; nirq goes low one cycle after eligible is first seen.
  - REQ: nirq=0.
    - If eligible drops (request withdrawn, masked, or int_en=0) and cpu_iack=0, go to IDLE; nirq returns high next cycle.
    - If cpu_iack=1, latch win = cand (or none) and go to VEC.
  - VEC (one cycle):
    - With a winner: vector_valid=1, vector=VECBASE+2*win, clr_irq[win]=1, in_service[win] set, nirq=1.
    - With no winner: vector=SPURIOUS, no clear, in_service unchanged.
    - Go to HOLD.
  - HOLD: nirq=1. Wait for cpu_iack=0, then go to IDLE. The next request is not raised until cpu_iack has been released.
- Latency: cpu_iack high at edge N gives vector_valid during cycle N+1.
- EOI: clears the lowest-numbered set bit of in_service at the next edge.
  - Accepted in any state.
  - In VEC the new in_service bit and the EOI are applied in the same edge: EOI clears the lowest bit of the pre-VEC in_service, and the new bit is set afterwards.
  - EOI with in_service=0 is ignored.
- Vector arithmetic is 16-bit modulo; wrap-around is not flagged.
- irq_pend may change at any cycle. The winner is frozen only at the REQ-to-VEC edge.
- Reset mid-handshake (REQ, VEC or HOLD) returns to IDLE with all outputs at their reset values. No clr_irq is emitted.

Decomposition:
- Shared package: state encoding (IDLE, REQ, VEC, HOLD), the NLINES constant, and the default VECBASE and SPURIOUS values.
- One natural sub-module: prio_enc8. It is combinational and takes an 8-bit input, producing a 3-bit index plus a found flag, lowest bit first. It is instantiated twice: once for irq_pend and once for in_service.

Test Plan:
- Reset: hold reset high with irq_pend=8'hFF, then release -> nirq=1, in_service=0 during reset; nirq=0 one cycle after release.
- Single request: irq_pend=8'h10, int_en=1, then cpu_iack -> vector=0x0010, clr_irq=8'h10, in_service=8'h10, nirq high until cpu_iack drops.
- Priority and nesting:
  - irq_pend=8'h50 acknowledged -> vector 0x0010.
  - Keep 8'h40 pending -> no nirq (IRQ6 is below in-service IRQ4).
  - Raise IRQ1 -> nirq low, vector 0x000A, in_service=8'h12.
  - eoi -> in_service=8'h10.
- Withdrawal and spurious:
  - Set irq_pend=8'h04, then clear it before cpu_iack -> nirq high again one cycle later.
  - Clear it in the same cycle cpu_iack rises -> vector=0x0020, clr_irq=0, in_service unchanged.
- int_en gating: int_en=0 with irq_pend=8'hFF -> nirq stays 1. Setting int_en=1 -> nirq low next cycle, then vector 0x0008.
- Edge cases:
  - eoi during VEC with in_service=8'h20 and winner IRQ2 -> in_service=8'h04.
  - Reset asserted in HOLD -> IDLE, all outputs at reset values.
